// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional SEQ_DIVIDER_EARLY_OUT_EN skips iteration when |divisor| > |dividend|.
module seq_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] rem_q, quot_q, dvsr_q;
    logic [CW-1:0]   cnt_q;
    logic            is_rem_q, neg_q_q, neg_r_q;

    logic            in_signed, div_zero, ovf;
    logic [XLEN-1:0] abs_a, abs_b, q_fix, r_fix;
    logic [XLEN:0]   shifted, trial;

    always_comb begin
        in_signed = ~op_i[0];
        abs_a     = (in_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
        abs_b     = (in_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
        div_zero  = (divisor_i == '0);
        ovf       = in_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
        // The shifted partial remainder can reach 2*|divisor|-1, hence XLEN+1 bits.
        shifted   = {rem_q, quot_q[XLEN-1]};
        trial     = shifted - {1'b0, dvsr_q};
        q_fix     = neg_q_q ? -quot_q : quot_q;
        r_fix     = neg_r_q ? -rem_q  : rem_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        is_rem_q <= op_i[1];
                        neg_q_q  <= in_signed & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_r_q  <= in_signed & dividend_i[XLEN-1];
                        dvsr_q   <= abs_b;
                        if (div_zero) begin
                            result_o <= op_i[1] ? dividend_i : '1;
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end else if (ovf) begin
                            result_o <= op_i[1] ? '0 : dividend_i;
                            valid_o  <= 1'b1;
                            state    <= DONE;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                        end else if (abs_b > abs_a) begin
                            quot_q <= '0;
                            rem_q  <= abs_a;
                            busy_o <= 1'b1;
                            state  <= FIX;
`endif
                        end else begin
                            quot_q <= abs_a;
                            rem_q  <= '0;
                            cnt_q  <= CW'(XLEN);
                            busy_o <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rem_q  <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                        quot_q <= {quot_q[XLEN-2:0], ~trial[XLEN]};
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy_o <= 1'b0;
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        result_o <= is_rem_q ? r_fix : q_fix;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expectations from a behavioural divide model,
// checked against result, latency and busy duration on each valid strobe.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, valid;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;
    exp_t sb[$];

    seq_divider #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .dividend_i(a), .divisor_i(b), .flush_i(flush),
        .busy_o(busy), .valid_o(valid), .result_o(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        if (y == 32'd0)                                          return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)   return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'd0:    return sx / sy;
            2'd1:    return x / y;
            2'd2:    return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx, my;
        mx = (!o[0] && x[31]) ? 32'd0 - x : x;
        my = (!o[0] && y[31]) ? 32'd0 - y : y;
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (my > mx) return 2;
`endif
        return 34;
    endfunction

    // Pulse start for one edge; called just after a clock edge (or at a negedge).
    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_done);
        exp_t e;
        if (expect_done) begin
            e.res  = model_res(o, x, y);
            e.lat  = model_lat(o, x, y);
            e.name = nm;
            sb.push_back(e);
        end
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Count cycles to valid; lat is the edge number (edge 1 sampled start) whose cycle shows valid.
    task automatic wait_valid(output logic [31:0] got, output int lat, output int busy_cyc,
                              output logic vnext, output bit timeout);
        lat = 1; busy_cyc = 0; timeout = 0; got = 'x; vnext = 'x;
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (valid) begin
                got = result;
                break;
            end
            if (lat >= 100) begin
                timeout = 1;
                break;
            end
            @(posedge clk); #1 lat++;
        end
        @(posedge clk); #1 vnext = valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, valid, result} !== 34'd0) begin
            fails++;
            $display("FAIL reset: busy=%b valid=%b result=%h, required 0 0 00000000", busy, valid, result);
        end
        @(posedge clk); #1 rst = 1'b0;
        last_res = 32'd0;
    endtask

    task automatic test_unsigned();
        logic [1:0]  ops[5] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        logic [31:0] xs[5]  = '{32'd100, 32'd100, 32'd1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ys[5]  = '{32'd7, 32'd7, 32'd3, 32'h0001_0000, 32'd1};
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e;
        foreach (ops[i]) begin
            issue("unsigned", ops[i], xs[i], ys[i], 1);
            wait_valid(got, lat, bc, vn, to);
            e = sb.pop_front();
            tests++;
            if (to || got !== e.res || lat != e.lat || bc != e.lat - 1 || vn !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d]: result=%h lat=%0d busy=%0d vnext=%b timeout=%0d, required result=%h lat=%0d busy=%0d vnext=0",
                         e.name, i, got, lat, bc, vn, to, e.res, e.lat, e.lat - 1);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_signed();
        logic [1:0]  ops[6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        logic [31:0] xs[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
        logic [31:0] ys[6]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e;
        foreach (ops[i]) begin
            issue("signed", ops[i], xs[i], ys[i], 1);
            wait_valid(got, lat, bc, vn, to);
            e = sb.pop_front();
            tests++;
            if (to || got !== e.res || lat != e.lat || bc != e.lat - 1) begin
                fails++;
                $display("FAIL %s[%0d]: result=%h lat=%0d busy=%0d timeout=%0d, required result=%h lat=%0d busy=%0d",
                         e.name, i, got, lat, bc, to, e.res, e.lat, e.lat - 1);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops[7] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
        logic [31:0] xs[7]  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] ys[7]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e;
        foreach (ops[i]) begin
            issue("special", ops[i], xs[i], ys[i], 1);
            wait_valid(got, lat, bc, vn, to);
            e = sb.pop_front();
            tests++;
            if (to || got !== e.res || lat != e.lat || bc != e.lat - 1 || vn !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d]: result=%h lat=%0d busy=%0d vnext=%b timeout=%0d, required result=%h lat=%0d busy=%0d vnext=0",
                         e.name, i, got, lat, bc, vn, to, e.res, e.lat, e.lat - 1);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_early_out();
        logic [1:0]  ops[3] = '{2'd1, 2'd2, 2'd0};
        logic [31:0] xs[3]  = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        logic [31:0] ys[3]  = '{32'd10, 32'd10, 32'hFFFF_FFF6};
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e;
        foreach (ops[i]) begin
            issue("early_out", ops[i], xs[i], ys[i], 1);
            wait_valid(got, lat, bc, vn, to);
            e = sb.pop_front();
            tests++;
            if (to || got !== e.res || lat != e.lat || bc != e.lat - 1) begin
                fails++;
                $display("FAIL %s[%0d]: result=%h lat=%0d busy=%0d timeout=%0d, required result=%h lat=%0d busy=%0d",
                         e.name, i, got, lat, bc, to, e.res, e.lat, e.lat - 1);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_flush();
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e; bit sawv;
        sawv = 0;
        // Flush during CALC, then relaunch one cycle later.
        issue("flush_calc", 2'd1, 32'd1000, 32'd3, 0);
        repeat (9) begin
            @(negedge clk); if (valid) sawv = 1;
            @(posedge clk);
        end
        #1 flush = 1'b1;
        @(negedge clk); if (valid) sawv = 1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        tests++;
        if (sawv || busy !== 1'b0 || valid !== 1'b0 || result !== last_res) begin
            fails++;
            $display("FAIL flush_calc: sawvalid=%0d busy=%b valid=%b result=%h, required 0 0 0 %h",
                     sawv, busy, valid, result, last_res);
        end
        issue("flush_restart", 2'd1, 32'd1000, 32'd3, 1);
        wait_valid(got, lat, bc, vn, to);
        e = sb.pop_front();
        tests++;
        if (to || got !== 32'd333 || got !== e.res || lat != e.lat) begin
            fails++;
            $display("FAIL %s: result=%h lat=%0d timeout=%0d, required result=%h lat=%0d",
                     e.name, got, lat, to, e.res, e.lat);
        end
        last_res = e.res;

        // Flush while in FIX: issue at edge 1, FIX occupies the cycle after edge 33.
        sawv = 0;
        issue("flush_fix", 2'd1, 32'd77, 32'd5, 0);
        repeat (32) begin
            @(negedge clk); if (valid) sawv = 1;
            @(posedge clk);
        end
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (4) begin
            @(negedge clk); if (valid || busy) sawv = 1;
        end
        tests++;
        if (sawv || result !== last_res) begin
            fails++;
            $display("FAIL flush_fix: saw valid/busy=%0d result=%h, required 0 %h", sawv, result, last_res);
        end

        // Flush and start together in IDLE: nothing launches.
        sawv = 0;
        @(posedge clk); #1;
        op = 2'd1; a = 32'd9; b = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        repeat (3) begin
            @(negedge clk); if (valid || busy) sawv = 1;
        end
        tests++;
        if (sawv || result !== last_res) begin
            fails++;
            $display("FAIL flush_start_idle: saw valid/busy=%0d result=%h, required 0 %h", sawv, result, last_res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e;
        issue("start_busy", 2'd1, 32'd100, 32'd7, 1);
        repeat (3) @(posedge clk);
        #1 op = 2'd0; a = 32'd5; b = 32'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(got, lat, bc, vn, to);
        e = sb.pop_front();
        tests++;
        if (to || got !== e.res || lat + 4 != e.lat) begin
            fails++;
            $display("FAIL %s: result=%h lat=%0d timeout=%0d, required result=%h lat=%0d",
                     e.name, got, lat + 4, to, e.res, e.lat);
        end
        last_res = e.res;
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] got; int lat, bc; logic vn; bit to; exp_t e;
        issue("reset_mid", 2'd1, 32'd100, 32'd7, 0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({busy, valid, result} !== 34'd0) begin
            fails++;
            $display("FAIL reset_mid_calc: busy=%b valid=%b result=%h, required 0 0 00000000", busy, valid, result);
        end
        @(posedge clk); #1 rst = 1'b0;
        last_res = 32'd0;
        issue("after_reset", 2'd3, 32'd1000, 32'd7, 1);
        wait_valid(got, lat, bc, vn, to);
        e = sb.pop_front();
        tests++;
        if (to || got !== e.res || lat != e.lat) begin
            fails++;
            $display("FAIL %s: result=%h lat=%0d timeout=%0d, required result=%h lat=%0d",
                     e.name, got, lat, to, e.res, e.lat);
        end
        last_res = e.res;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, x, y; logic [1:0] o; int lat, bc; logic vn; bit to; exp_t e;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(0, 31);
            issue("random", o, x, y, 1);
            wait_valid(got, lat, bc, vn, to);
            e = sb.pop_front();
            tests++;
            if (to || got !== e.res || lat != e.lat || bc != e.lat - 1) begin
                fails++;
                $display("FAIL %s[%0d] op=%0d %h/%h: result=%h lat=%0d busy=%0d timeout=%0d, required result=%h lat=%0d busy=%0d",
                         e.name, i, o, x, y, got, lat, bc, to, e.res, e.lat, e.lat - 1);
            end
            last_res = e.res;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_early_out();
        test_flush();
        test_start_while_busy();
        test_reset_mid_calc();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU operations.
- Sits in the execute stage beside the single-cycle ALU.
- The ALU decodes OP_DIV/OP_DIVU/OP_REM/OP_REMU from the decoder's alu_ctrl field into op_i and pulses start_i.
- The pipeline stalls on busy_o and takes result_o when valid_o pulses.

Parameters:
- XLEN, 32, operand and result width in bits. Fixed at 32 for RV32; the iteration counter is $clog2(XLEN)+1 bits wide.

Ports:
- clk_i  input  1  core clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  launch request; sampled only in IDLE
- op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- dividend_i  input  XLEN  rs1 value
- divisor_i  input  XLEN  rs2 value
- flush_i  input  1  pipeline flush; abandons the current operation
- busy_o  output  1  high from the cycle after start is accepted until valid_o
- valid_o  output  1  one-cycle result strobe
- result_o  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start

Behaviour:
- Reset: state=IDLE; busy_o=0; valid_o=0; result_o=0; all internal registers 0. Reset takes effect asynchronously at any time, including mid-CALC.
- States: IDLE, CALC, FIX, DONE.
- IDLE
  - If start_i=1, latch the operands and op_i.
  - signed = ~op_i[0]; rem = op_i[1].
  - In signed mode, take magnitudes of both operands; record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Divisor == 0: pre-load result = all-ones (quotient) or dividend (remainder); go to DONE.
  - Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, signed op): result = 0x80000000 (quotient) or 0 (remainder); go to DONE.
  - Otherwise go to CALC with counter=XLEN, partial remainder=0, quotient register=|dividend|.
- CALC, one iteration per cycle:
  - Shift {rem,quot} left by 1; trial = rem - |divisor| (XLEN+1 bits).
  - If trial is non-negative: rem=trial[XLEN-1:0] and quot LSB=1; else quot LSB=0.
  - Counter decrements each cycle; after XLEN iterations go to FIX.
- FIX: apply sign correction (negate quot if neg_q, negate rem if neg_r, signed ops only); select quot or rem into result_o; go to DONE.
- DONE: valid_o=1 for exactly this cycle; busy_o=0; next state IDLE. start_i in DONE is ignored.
- Latency, counting from the edge that samples start_i:
  - Normal: valid_o is high in the cycle after edge 34 (XLEN+2).
  - Special case: valid_o is high in the cycle after edge 1.
- busy_o=1 in CALC and FIX.
- start_i while busy is ignored; the operands are not relatched.
- flush_i=1 in CALC or FIX: next state IDLE, no valid_o, result_o unchanged.
- flush_i in DONE suppresses nothing: valid_o still pulses and the consumer discards it.
- flush_i and start_i together in IDLE: flush wins, nothing is launched.
- result_o changes only on FIX or special-case entry to DONE.
- No X propagation: unused op_i encodings do not exist because all 4 are defined.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE, if neither special case applies and |divisor| > |dividend| (unsigned compare of magnitudes), skip CALC.
  - Pre-load quot=0, rem=|dividend|, go directly to FIX.
  - valid_o is then high in the cycle after edge 2.
  - Sign correction applies normally.
- Undefined: no magnitude comparator; every non-special operation takes the full XLEN+2 latency.

Test Plan:
- DIVU 100/7 -> valid_o after 34 cycles, result_o=14. REMU 100/7 -> result_o=2. busy_o high for exactly 33 cycles.
- DIV -7/2 (0xFFFFFFF9, 2) -> result_o=0xFFFFFFFD (-3). REM -7/2 -> result_o=0xFFFFFFFF (-1). Covers truncation toward zero.
- Divide by zero, DIV 5/0 -> result_o=0xFFFFFFFF with valid_o after 1 cycle. REM 5/0 -> result_o=5.
- Signed overflow, DIV 0x80000000/0xFFFFFFFF -> result_o=0x80000000 after 1 cycle. REM of the same operands -> result_o=0.
- Control events:
  - Start DIVU 1000/3, assert flush_i at cycle 10 -> no valid_o, busy_o=0 next cycle, result_o keeps its previous value.
  - A new start at cycle 12 completes normally with result_o=333.
  - start_i pulsed mid-CALC is ignored.
  - rst_i asserted mid-CALC -> all outputs 0 immediately.
- With SEQ_DIVIDER_EARLY_OUT_EN: DIVU 3/10 -> result_o=0 after 2 cycles. REM -3/10 -> result_o=0xFFFFFFFD after 2 cycles. Without the macro, both take 34 cycles with the same values.
